uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
Parameters:
REQ-001 The block SHALL have the parameter DEPTH_LOG2, default 5, which is log2 of the number of receive-queue entries.

Ports:
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port baud_div_i, input, 16 bits: the bit period in clocks is baud_div_i+1, matching the transmitter.
REQ-005 The block SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port re_i, input, 1 bit: pop request; pops the head entry when empty_o=0.
REQ-007 The block SHALL have port clr_i, input, 1 bit: clears the sticky error flags.
REQ-008 The block SHALL have port data_o, output, 8 bits: the queue head (show-ahead); undefined when empty_o=1.
REQ-009 The block SHALL have port empty_o, output, 1 bit: 1 = no byte available.
REQ-010 The block SHALL have port full_o, output, 1 bit: 1 = queue full (2^DEPTH_LOG2-1 entries).
REQ-011 The block SHALL have port overrun_o, output, 1 bit: sticky; set when a valid byte was dropped because the queue was full.
REQ-012 The block SHALL have port frame_err_o, output, 1 bit: sticky; set when a stop bit was sampled as 0.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer to give rx_s; all line decisions SHALL use rx_s only.
REQ-014 The FSM SHALL have these states: IDLE, START, DATA (bit index 0..7), STOP.
REQ-015 In IDLE, a falling edge on rx_s (previous 1, current 0) SHALL move the FSM to START and clear the bit counter.
REQ-016 In START, when counter == baud_div_i>>1 (mid start bit): if rx_s=0, the FSM SHALL go to DATA with index 0 and clear the counter; otherwise it SHALL return to IDLE (glitch rejected, nothing stored).
REQ-017 In DATA, when counter == baud_div_i, rx_s SHALL be stored as bit[index] (LSB first) and the counter cleared; after index 7 the FSM SHALL go to STOP.
REQ-018 In all other cycles in START, DATA and STOP, the counter SHALL increment by 1 (16-bit).
REQ-019 In STOP, when counter == baud_div_i, the FSM SHALL go to IDLE, and:
- if rx_s=1 and the queue is not full, the byte SHALL be written at write_ptr and write_ptr incremented;
- if rx_s=1 and the queue is full, the byte SHALL be dropped and overrun_o set;
- if rx_s=0, the byte SHALL be dropped and frame_err_o set.
REQ-020 After a framing error, the FSM SHALL return to IDLE and wait for a fresh 1->0 edge; a line held low (break) SHALL NOT produce further bytes.
REQ-021 The queue SHALL be circular with DEPTH_LOG2-bit read and write pointers that wrap naturally.
REQ-022 empty_o SHALL equal (read_ptr == write_ptr).
REQ-023 full_o SHALL equal (write_ptr+1 == read_ptr), giving 2^DEPTH_LOG2-1 usable entries.
REQ-024 data_o SHALL equal queue[read_ptr], combinationally.
REQ-025 re_i with empty_o=1 SHALL be ignored.
REQ-026 A push and a pop in the same cycle SHALL both take effect; when full, the push is still refused in that cycle, because full_o is evaluated before the pop.
REQ-027 Latency: empty_o SHALL fall in the cycle after the STOP sample cycle.
REQ-028 clr_i SHALL clear both error flags the next cycle; if a set event coincides with clr_i, set SHALL win.
REQ-029 A change of baud_div_i mid-frame is unsupported; the behaviour SHALL only need to be defined at frame boundaries.

Reset
REQ-030 rst_i=1 SHALL set the FSM to IDLE and clear the counter, pointers, shift register, overrun_o and frame_err_o; the synchronizer flops SHALL reset to 1; after reset empty_o=1 and full_o=0.
REQ-031 Reset mid-frame SHALL discard the partial byte; the next frame SHALL be received only after a new falling edge.
REQ-032 Queue contents SHALL NOT require reset.

Verification
REQ-033 baud_div_i=15, frame 0x55 (start, LSB first, stop=1) -> empty_o falls 1 cycle after the stop sample; data_o=0x55; re_i pulse -> empty_o=1.
REQ-034 A 4-clock low glitch on rx_i, baud_div_i=15 -> rejected in START; empty_o stays 1 and no flags are set.
REQ-035 Frame 0xA3 with stop bit=0 -> frame_err_o=1, empty_o=1; clr_i -> frame_err_o=0; next frame 0x3C is received correctly.
REQ-036 32 frames 0x00..0x1F with no reads -> full_o=1 after 31 frames; 32nd frame dropped with overrun_o=1; reads return 0x00..0x1E in order.
REQ-037 Pop in the same cycle as a push with 1 entry stored -> count stays 1; order is preserved across pointer wrap (≥40 bytes streamed with interleaved reads).
REQ-038 rst_i asserted during DATA bit 4 -> all outputs at reset values; a subsequent full frame 0xC6 is received intact.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
//============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. The serial input is synchronised, framed by
//            a bit-period counter (period = baud_div_i + 1 clocks), and each
//            good byte is pushed into a show-ahead circular receive queue.
//            Sticky overrun and framing error flags are kept alongside.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous active-high reset
//            baud_div_i   - bit period minus one, in clocks
//            rx_i         - asynchronous serial line, idle high
//            re_i         - pop the head entry (ignored when empty)
//            clr_i        - clear sticky error flags
//            data_o       - queue head (valid when empty_o = 0)
//            empty_o      - no byte available
//            full_o       - queue holds 2^DEPTH_LOG2-1 entries
//            overrun_o    - sticky: good byte dropped on full queue
//            frame_err_o  - sticky: stop bit sampled low
// Revision : 1.0 - initial release
//============================================================================
module uart_rx #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] baud_div_i,
    input  logic        rx_i,
    input  logic        re_i,
    input  logic        clr_i,
    output logic [7:0]  data_o,
    output logic        empty_o,
    output logic        full_o,
    output logic        overrun_o,
    output logic        frame_err_o
);

    localparam int                  c_depth   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchroniser and edge detector
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx_s;

    // Framing state
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_push;
    logic        w_set_ovr;
    logic        w_set_fe;

    // Receive queue
    logic [7:0]            r_mem [0:c_depth-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2-1:0] w_wptr_inc;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    logic r_ovr;
    logic r_fe;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx_s;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next state and per-frame actions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_set_ovr   = 1'b0;
        w_set_fe    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = r_cnt;
                // Only a genuine 1->0 transition starts a frame, so a line
                // held low after a framing error cannot retrigger.
                if (r_rx_prev && !w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_START: begin
                if (r_cnt == (baud_div_i >> 1)) begin
                    w_cnt_nxt = 16'd0;
                    if (!w_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == baud_div_i) begin
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_cnt_nxt          = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == baud_div_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                    if (w_rx_s) begin
                        // Fullness is judged before any same-cycle pop.
                        if (!w_full) begin
                            w_push = 1'b1;
                        end else begin
                            w_set_ovr = 1'b1;
                        end
                    end else begin
                        w_set_fe = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    assign w_wptr_inc = r_wptr + c_ptr_one;
    assign w_full     = (w_wptr_inc == r_rptr);
    assign w_empty    = (r_rptr == r_wptr);
    assign w_pop      = re_i && !w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Queue storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_i wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            r_ovr <= w_set_ovr || (r_ovr && !clr_i);
            r_fe  <= w_set_fe  || (r_fe  && !clr_i);
        end
    end

    assign data_o      = r_mem[r_rptr];
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign overrun_o   = r_ovr;
    assign frame_err_o = r_fe;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
//============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Drives serial frames bit by
//            bit and compares the queue outputs and flags with a reference
//            model made of a byte queue and two flag bits.
// Revision : 1.0 - initial release
//============================================================================
module tb_uart_rx;

    localparam int DL  = 5;
    localparam int CAP = (2 ** DL) - 1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] baud_div_i;
    logic        rx_i;
    logic        re_i;
    logic        clr_i;
    logic [7:0]  data_o;
    logic        empty_o;
    logic        full_o;
    logic        overrun_o;
    logic        frame_err_o;

    int n_err = 0;
    int n_chk = 0;

    // Reference model
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.DEPTH_LOG2(DL)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .baud_div_i  (baud_div_i),
        .rx_i        (rx_i),
        .re_i        (re_i),
        .clr_i       (clr_i),
        .data_o      (data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/empty"}, {31'd0, empty_o}, {31'd0, (mq.size() == 0)});
        chk({tag, "/full"},  {31'd0, full_o},  {31'd0, (mq.size() == CAP)});
        chk({tag, "/ovr"},   {31'd0, overrun_o},   {31'd0, m_ovr});
        chk({tag, "/fe"},    {31'd0, frame_err_o}, {31'd0, m_fe});
        if (mq.size() > 0) begin
            chk({tag, "/data"}, {24'd0, data_o}, {24'd0, mq[0]});
        end
    endtask

    // Serialises one frame (start, 8 data bits LSB first, stop) starting on
    // the current cycle. Edges are counted from the first start-bit cycle so
    // the stop-sample edge can be predicted: 2 synchroniser edges, 1 edge to
    // enter START, half a bit plus 1 to leave it, then 9 full bit periods.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit chk_lat, input bit pop_at_push,
                              input bit hold_low);
        int          bp;
        int          tgt;
        int          tail;
        logic [9:0]  bits;
        logic        was_full;
        bp   = int'(baud_div_i) + 1;
        tgt  = 4 + int'(baud_div_i >> 1) + 9 * bp;
        tail = hold_low ? 3 * bp : 4;
        bits = {stop_bit, b, 1'b0};
        for (int n = 0; n < 10 * bp + tail; n++) begin
            if (n < 10 * bp) rx_i = bits[n / bp];
            else             rx_i = hold_low ? 1'b0 : 1'b1;
            tick();
            if (chk_lat && (n + 1 == tgt - 1)) chk("lat_before", {31'd0, empty_o}, 32'd1);
            if (chk_lat && (n + 1 == tgt))     chk("lat_after",  {31'd0, empty_o}, 32'd0);
            if (pop_at_push && (n + 1 == tgt - 1)) re_i = 1'b1;
            if (pop_at_push && (n + 1 == tgt))     re_i = 1'b0;
        end
        if (hold_low) begin
            rx_i = 1'b1;
            for (int i = 0; i < 4; i++) tick();
        end
        was_full = (mq.size() == CAP);
        if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
        if (stop_bit) begin
            if (was_full) m_ovr = 1'b1;
            else          mq.push_back(b);
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic pop();
        if (mq.size() > 0) begin
            chk("pop/data", {24'd0, data_o}, {24'd0, mq[0]});
        end
        re_i = 1'b1;
        tick();
        re_i = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] rst_byte;
        bit         pa;
        rst_i      = 1'b1;
        rx_i       = 1'b1;
        re_i       = 1'b0;
        clr_i      = 1'b0;
        baud_div_i = 16'd15;
        for (int i = 0; i < 3; i++) tick();
        rst_i = 1'b0;
        tick();
        check_state("reset");

        // Single frame, exact push latency, pop back to empty
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        check_state("f55");
        pop();
        check_state("f55_pop");

        // Short low glitch is rejected in START
        rx_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rx_i = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check_state("glitch");

        // Framing error, clear, then a good frame
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("fe_a3");
        clr();
        check_state("fe_clr");
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        check_state("f3c");
        pop();

        // Break: one framing error only, no bytes while the line stays low
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("break");
        clr();

        // Fill the queue with 0x00..0x1F; the last one overruns
        for (int i = 0; i < 32; i++) begin
            send_frame(8'(i), 1'b1, (i == 0), 1'b0, 1'b0);
            if (i >= 30) check_state("fill");
        end
        // Push refused while full even though a pop happens on the same edge
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        check_state("full_pushpop");
        clr();
        while (mq.size() > 0) pop();
        check_state("drained");
        pop();
        check_state("pop_empty");

        // Same-cycle push and pop with one entry stored
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
        check_state("pushpop1");
        pop();
        check_state("pushpop1_pop");

        // Random stream across pointer wrap, baud changed between frames
        for (int i = 0; i < 45; i++) begin
            baud_div_i = 16'($urandom_range(4, 12));
            rb = 8'($urandom);
            pa = (mq.size() > 0) && ($urandom_range(0, 3) == 0);
            send_frame(rb, 1'b1, (mq.size() == 0) && !pa, pa, 1'b0);
            check_state("stream");
            if ($urandom_range(0, 1) == 1 || mq.size() > 20) pop();
        end
        while (mq.size() > 0) pop();
        check_state("stream_end");

        // Reset during data bit 4 with a stored byte and a flag pending
        baud_div_i = 16'd15;
        send_frame(8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_byte = 8'hFF;
        rx_i = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        for (int k = 0; k < 4; k++) begin
            rx_i = rst_byte[k];
            for (int i = 0; i < 16; i++) tick();
        end
        rx_i = rst_byte[4];
        for (int i = 0; i < 8; i++) tick();
        rst_i = 1'b1;
        rx_i  = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check_state("midreset");
        send_frame(8'hC6, 1'b1, 1'b1, 1'b0, 1'b0);
        check_state("fc6");
        pop();
        check_state("fc6_pop");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
